// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types and constants for the write-only master subsystem.
package axil_pkg;

  localparam int unsigned AXIL_RESP_W = 2;

  typedef enum logic [AXIL_RESP_W-1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEND   = 2'b01,
    RESP   = 2'b10,
    REPORT = 2'b11
  } wr_mst_state_t;

endpackage

// File: rtl/axil_valid_hold.sv
// Holds one AXI VALID until its handshake, then remembers that the channel finished.
module axil_valid_hold (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_ready,
  output logic o_valid,
  output logic o_done
);

  logic r_valid;
  logic r_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_start) begin
      r_valid <= 1'b1;
      r_done  <= 1'b0;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
      r_done  <= 1'b1;
    end
  end

  assign o_valid = r_valid;
  assign o_done  = r_done;

endmodule

// File: rtl/axil_wr_master.sv
// AXI4-Lite single-outstanding write initiator: one command -> one AW/W/B transaction.
// Optional AXIL_WR_ALIGN_CHECK_EN rejects misaligned addresses with SLVERR and no bus activity.
module axil_wr_master
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [DATA_WIDTH-1:0]  cmd_data,
  input  logic [STRB_WIDTH-1:0]  cmd_strb,
  output logic                   rsp_valid,
  output logic [AXIL_RESP_W-1:0] rsp_resp,
  output logic                   busy,
  output logic [ADDR_WIDTH-1:0]  AWADDR,
  output logic                   AWVALID,
  input  logic                   AWREADY,
  output logic [DATA_WIDTH-1:0]  WDATA,
  output logic [STRB_WIDTH-1:0]  WSTRB,
  output logic                   WVALID,
  input  logic                   WREADY,
  input  logic                   BVALID,
  input  logic [AXIL_RESP_W-1:0] BRESP,
  output logic                   BREADY
);

  wr_mst_state_t         r_state;
  logic                  r_cmd_ready;
  logic                  r_busy;
  logic                  r_bready;
  logic                  r_rsp_valid;
  resp_t                 r_rsp_resp;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;

  logic w_misaligned;
  logic w_accept;
  logic w_start;
  logic w_awvalid;
  logic w_wvalid;
  logic w_aw_done;
  logic w_w_done;
  logic w_aw_fin;
  logic w_w_fin;

`ifdef AXIL_WR_ALIGN_CHECK_EN
  localparam int unsigned LSB_W = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 1;
  assign w_misaligned = |cmd_addr[LSB_W-1:0];
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && r_cmd_ready && cmd_valid;
  assign w_start  = w_accept && !w_misaligned;

  // A channel counts as finished if it already handshook or is handshaking this edge.
  assign w_aw_fin = w_aw_done || (w_awvalid && AWREADY);
  assign w_w_fin  = w_w_done  || (w_wvalid  && WREADY);

  axil_valid_hold u_aw_hold (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_ready (AWREADY),
    .o_valid (w_awvalid),
    .o_done  (w_aw_done)
  );

  axil_valid_hold u_w_hold (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_ready (WREADY),
    .o_valid (w_wvalid),
    .o_done  (w_w_done)
  );

  // Transaction sequencing; every control output is a register of this block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_bready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_resp  <= OKAY;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_cmd_ready) begin
            r_cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            r_awaddr    <= cmd_addr;
            r_wdata     <= cmd_data;
            r_wstrb     <= cmd_strb;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (w_misaligned) begin
              r_rsp_valid <= 1'b1;
              r_rsp_resp  <= SLVERR;
              r_state     <= REPORT;
            end else begin
              r_state <= SEND;
            end
          end
        end
        SEND: begin
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_state  <= RESP;
          end
        end
        RESP: begin
          if (BVALID) begin
            r_rsp_resp  <= resp_t'(BRESP);
            r_rsp_valid <= 1'b1;
            r_bready    <= 1'b0;
            r_state     <= REPORT;
          end
        end
        REPORT: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign BREADY    = r_bready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_resp  = r_rsp_resp;
  assign AWADDR    = r_awaddr;
  assign WDATA     = r_wdata;
  assign WSTRB     = r_wstrb;
  assign AWVALID   = w_awvalid;
  assign WVALID    = w_wvalid;

endmodule

// File: tb/tb_axil_wr_master.sv
// Self-checking bench for axil_wr_master: directed + random transactions against a cycle-timing model.
module tb_axil_wr_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY = 1'b0;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY = 1'b0;
  logic        BVALID = 1'b0;
  logic [1:0]  BRESP = 2'b00;
  logic        BREADY;

  int n_pass  = 0;
  int n_total = 0;

  localparam int NRAND = 24;
  logic [31:0] r_a [NRAND+1];
  logic [31:0] r_d [NRAND+1];
  logic [3:0]  r_s [NRAND+1];

  axil_wr_master dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_strb  (cmd_strb),
    .rsp_valid (rsp_valid),
    .rsp_resp  (rsp_resp),
    .busy      (busy),
    .AWADDR    (AWADDR),
    .AWVALID   (AWVALID),
    .AWREADY   (AWREADY),
    .WDATA     (WDATA),
    .WSTRB     (WSTRB),
    .WVALID    (WVALID),
    .WREADY    (WREADY),
    .BVALID    (BVALID),
    .BRESP     (BRESP),
    .BREADY    (BREADY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Entered and left on a negedge with the DUT idle and ready. The model derives every
  // cycle's expected outputs from the handshake delays: AW/W finish at cycle 1+dly,
  // RESP starts the cycle after both, the one-cycle BVALID lands b_dly cycles into RESP.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int aw_dly, input int w_dly, input int b_dly,
                         input logic [1:0] br, input bit stray, input bit hold,
                         input logic [31:0] na, input logic [31:0] nd, input logic [3:0] ns);
    int e, rcyc, last;
    bit mis;
    logic [5:0] exp_v, obs_v;
    mis = 1'b0;
`ifdef AXIL_WR_ALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
`endif
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_strb  = s;
    check("accept_ready", 64'(cmd_ready), 64'd1);
    e    = 1 + ((aw_dly > w_dly) ? aw_dly : w_dly);
    rcyc = mis ? 1 : e + 2 + b_dly;
    last = rcyc + 1;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      cmd_valid = hold;
      if (hold) begin
        cmd_addr = na;
        cmd_data = nd;
        cmd_strb = ns;
      end
      AWREADY = (k >= 1 + aw_dly);
      WREADY  = (k >= 1 + w_dly);
      BVALID  = !mis && ((k == e + 1 + b_dly) || (stray && k == 1));
      BRESP   = (k == e + 1 + b_dly) ? br : ~br;
      if (mis)
        exp_v = {1'b0, 1'b0, 1'b0, k == 1, k == 1, k == 2};
      else
        exp_v = {k <= 1 + aw_dly, k <= 1 + w_dly, (k > e) && (k <= e + 1 + b_dly),
                 k == rcyc, k <= rcyc, k == last};
      obs_v = {AWVALID, WVALID, BREADY, rsp_valid, busy, cmd_ready};
      check($sformatf("ctl a=%08h k=%0d {awv,wv,brdy,rspv,busy,crdy}", a, k), 64'(obs_v), 64'(exp_v));
      if (exp_v[5]) check($sformatf("awaddr k=%0d", k), 64'(AWADDR), 64'(a));
      if (exp_v[4]) check($sformatf("wstrb_wdata k=%0d", k), 64'({WSTRB, WDATA}), 64'({s, d}));
      if (k == rcyc) check("rsp_resp", 64'(rsp_resp), mis ? 64'd2 : 64'(br));
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ctl", 64'({AWVALID, WVALID, BREADY, rsp_valid, busy, cmd_ready, rsp_resp}), 64'd0);
    check("reset_payload", 64'({AWADDR, WDATA} ^ {28'd0, WSTRB}), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_release", 64'(cmd_ready), 64'd1);

    // Minimum latency, OKAY
    run_txn(32'h0000_0100, 32'h1234_5678, 4'hF, 0, 0, 0, 2'b00, 1'b0, 1'b0, '0, '0, '0);
    // AWREADY held off five cycles
    run_txn(32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 5, 0, 0, 2'b00, 1'b0, 1'b0, '0, '0, '0);
    // AW first, then W, then a late one-cycle BVALID
    run_txn(32'h0000_2008, 32'hCAFE_F00D, 4'h3, 0, 2, 1, 2'b00, 1'b0, 1'b0, '0, '0, '0);
    // DECERR with the next command already waiting, plus a stray early BVALID
    run_txn(32'h0000_300C, 32'hA5A5_5A5A, 4'hC, 1, 1, 2, 2'b11, 1'b1, 1'b1,
            32'h0000_4010, 32'h0BAD_F00D, 4'h9);
    run_txn(32'h0000_4010, 32'h0BAD_F00D, 4'h9, 0, 3, 0, 2'b01, 1'b0, 1'b0, '0, '0, '0);
    // Low address bits: passed through, or rejected when the alignment check is built in
    run_txn(32'h0000_0002, 32'h1111_2222, 4'h1, 0, 0, 0, 2'b00, 1'b0, 1'b0, '0, '0, '0);

    // Reset while waiting in RESP
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_5014;
    cmd_data  = 32'h5555_AAAA;
    cmd_strb  = 4'hF;
    AWREADY   = 1'b1;
    WREADY    = 1'b1;
    BVALID    = 1'b0;
    check("rst_pre_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_in_resp_bready", 64'(BREADY), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("rst_async_clear", 64'({AWVALID, WVALID, BREADY, busy, rsp_valid, cmd_ready}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_rst rspv/crdy %0d", i), 64'({rsp_valid, cmd_ready}), 64'b01);
    end

    // Random transactions; a held next command chains directly into the following one
    for (int i = 0; i <= NRAND; i++) begin
      r_a[i] = $urandom;
      r_d[i] = $urandom;
      r_s[i] = 4'($urandom_range(0, 15));
    end
    for (int i = 0; i < NRAND; i++) begin
      run_txn(r_a[i], r_d[i], r_s[i],
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              r_a[i+1], r_d[i+1], r_s[i+1]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
